// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/ack port, ID-stage
// control (redirect/stall) and the head-of-queue view presented to IF/ID.
interface fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        redirect;
    logic [31:0] redirect_addr;
    logic        stall;

    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;

    // The fetch queue itself drives requests and the head entry
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  redirect,
        input  redirect_addr,
        input  stall,
        output out_valid,
        output out_instr,
        output out_pc_plus4
    );

    // Memory plus decode stage as seen from outside the queue
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output redirect,
        output redirect_addr,
        output stall,
        input  out_valid,
        input  out_instr,
        input  out_pc_plus4
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding request engine to a
// multi-cycle instruction memory feeding a DEPTH-entry prefetch FIFO that
// presents {instruction, pc+4} to the IF/ID register.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_fetchPc;
    logic             r_memReq;
    logic [31:0]      r_memAddr;

    logic [31:0]      r_instrStore [DEPTH];
    logic [31:0]      r_pcStore    [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [31:0]      w_redirectAddr;
    logic [31:0]      w_pcPlus4;
    logic [31:0]      w_discardTarget;
    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic             w_credit;
    logic [PTR_W:0]   w_countNext;
    logic             w_unused;

    // Low target bits are architecturally ignored; fetches are word aligned
    assign w_redirectAddr = {bus.redirect_addr[31:2], 2'b00};
    assign w_unused       = &{1'b0, bus.redirect_addr[1:0]};

    assign w_pcPlus4 = r_memAddr + 32'd4;

    // An ack only means something while a request is actually out
    assign w_ack = bus.mem_ack && r_memReq;

    // Data is kept only for a wanted request and never in a flush cycle
    assign w_push = w_ack && (r_state == S_WAIT) && !bus.redirect;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && !bus.stall && !bus.redirect;

    // A stale request completing in DISCARD restarts at the newest target
    assign w_discardTarget = bus.redirect ? w_redirectAddr : r_fetchPc;

    // Occupancy after this cycle's push, pop or flush
    always_comb begin
        w_countNext = r_count;
        if (bus.redirect) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_ONE;
        end
    end

    // Issuing only happens when no other request remains in flight, so the
    // post-update occupancy alone decides whether a new slot can be reserved
    assign w_credit = (w_countNext < CNT_DEPTH);

    // Head entry, forced to zero while the queue is empty
    assign bus.out_valid    = w_valid;
    assign bus.out_instr    = w_valid ? r_instrStore[r_head] : 32'd0;
    assign bus.out_pc_plus4 = w_valid ? r_pcStore[r_head]    : 32'd0;

    assign bus.mem_req  = r_memReq;
    assign bus.mem_addr = r_memAddr;

    // FIFO payload storage; contents only matter under a valid pointer range
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrStore[r_tail] <= bus.mem_rdata;
            r_pcStore[r_tail]    <= w_pcPlus4;
        end
    end

    // FIFO pointers and occupancy, emptied outright on a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
            if (bus.redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
            end
        end
    end

    // Request engine: issue, wait for the ack, or discard a stale response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_fetchPc <= RESET_PC;
            r_memReq  <= 1'b0;
            r_memAddr <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.redirect) begin
                        r_fetchPc <= w_redirectAddr;
                    end
                    if (w_credit) begin
                        r_memReq  <= 1'b1;
                        r_memAddr <= bus.redirect ? w_redirectAddr : r_fetchPc;
                        r_state   <= S_WAIT;
                    end else begin
                        r_memReq <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (w_ack) begin
                        if (bus.redirect) begin
                            r_fetchPc <= w_redirectAddr;
                            r_memAddr <= w_redirectAddr;
                            r_memReq  <= 1'b1;
                        end else begin
                            r_fetchPc <= w_pcPlus4;
                            if (w_credit) begin
                                r_memAddr <= w_pcPlus4;
                                r_memReq  <= 1'b1;
                            end else begin
                                r_memReq <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end
                    end else if (bus.redirect) begin
                        r_fetchPc <= w_redirectAddr;
                        r_state   <= S_DISCARD;
                    end
                end

                S_DISCARD: begin
                    if (w_ack) begin
                        r_fetchPc <= w_discardTarget;
                        r_memAddr <= w_discardTarget;
                        r_memReq  <= 1'b1;
                        r_state   <= S_WAIT;
                    end else if (bus.redirect) begin
                        r_fetchPc <= w_redirectAddr;
                    end
                end

                default: begin
                    r_memReq <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall back-pressure, redirect
// during a slow fetch, redirect on an ack, unaligned target and mid-fetch reset.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;

    logic        memAuto;
    int          latency;
    int          waitCnt;
    logic        modelAck;
    logic [31:0] modelData;
    logic        manualAck;
    logic [31:0] manualData;

    int          checkCount;
    int          passCount;

    logic        stallReqExp [6];

    fetch_queue_if fq ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fq.master)
    );

    assign fq.mem_ack   = memAuto ? modelAck  : manualAck;
    assign fq.mem_rdata = memAuto ? modelData : manualData;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks `latency` half-period samples after seeing a request
    always @(negedge clk) begin
        if (!memAuto || !fq.mem_req) begin
            modelAck = 1'b0;
            waitCnt  = 0;
        end else if (waitCnt == latency - 1) begin
            modelAck  = 1'b1;
            modelData = 32'hC0DE_0000 ^ fq.mem_addr;
            waitCnt   = 0;
        end else begin
            modelAck = 1'b0;
            waitCnt  = waitCnt + 1;
        end
    end

    // The credit scheme must never let a push land on a full queue
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            assert (!(dut.w_push && int'(dut.r_count) == DEPTH))
            else $error("[TB] FAIL fifoPushWhenFull count=%0d required<%0d", dut.r_count, DEPTH);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end else begin
            passCount = passCount + 1;
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] target, input logic stl);
        fq.redirect      = redir;
        fq.redirect_addr = target;
        fq.stall         = stl;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount  = 0;
        passCount   = 0;
        memAuto     = 1'b1;
        latency     = 1;
        waitCnt     = 0;
        modelAck    = 1'b0;
        modelData   = 32'd0;
        manualAck   = 1'b0;
        manualData  = 32'd0;
        stallReqExp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst_n       = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);

        // Reset state
        repeat (3) waitCycle();
        checkOutput("rstReq",   {31'd0, fq.mem_req},   32'd0);
        checkOutput("rstAddr",  fq.mem_addr,           32'd0);
        checkOutput("rstValid", {31'd0, fq.out_valid}, 32'd0);
        checkOutput("rstInstr", fq.out_instr,          32'd0);
        checkOutput("rstPc4",   fq.out_pc_plus4,       32'd0);

        // Zero-wait streaming
        rst_n = 1'b1;
        waitCycle();
        checkOutput("s1Req",   {31'd0, fq.mem_req},   32'd1);
        checkOutput("s1Addr",  fq.mem_addr,           32'd0);
        checkOutput("s1Valid", {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        checkOutput("s2Addr",  fq.mem_addr,           32'd4);
        checkOutput("s2Valid", {31'd0, fq.out_valid}, 32'd1);
        checkOutput("s2Pc4",   fq.out_pc_plus4,       32'd4);
        checkOutput("s2Instr", fq.out_instr,          32'hC0DE_0000);
        for (int n = 3; n <= 4; n++) begin
            waitCycle();
            checkOutput("streamAddr", fq.mem_addr,     32'(4 * (n - 1)));
            checkOutput("streamPc4",  fq.out_pc_plus4, 32'(4 * (n - 1)));
        end

        // Six stalled cycles: head holds, queue fills, requests stop
        applyStimulus(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            waitCycle();
            checkOutput("stallPc4", fq.out_pc_plus4,        32'd12);
            checkOutput("stallReq", {31'd0, fq.mem_req},    {31'd0, stallReqExp[i]});
        end
        checkOutput("stallInstr", fq.out_instr, 32'hC0DE_0008);

        // Release: fetch resumes at 24 without skipping or repeating
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitCycle();
        checkOutput("resumeReq",   {31'd0, fq.mem_req}, 32'd1);
        checkOutput("resumeAddr",  fq.mem_addr,         32'd24);
        checkOutput("resumePc4",   fq.out_pc_plus4,     32'd16);
        checkOutput("resumeInstr", fq.out_instr,        32'hC0DE_000C);
        waitCycle();
        checkOutput("resumeAddr2", fq.mem_addr,     32'd28);
        checkOutput("resumePc4b",  fq.out_pc_plus4, 32'd20);
        waitCycle();
        checkOutput("resumePc4c",  fq.out_pc_plus4, 32'd24);
        waitCycle();
        checkOutput("resumePc4d",  fq.out_pc_plus4, 32'd28);

        // Slow memory, redirect to 0x40 in the second wait cycle
        rst_n   = 1'b0;
        latency = 3;
        waitCycle();
        checkOutput("t3RstValid", {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("t3Req1",  {31'd0, fq.mem_req}, 32'd1);
        checkOutput("t3Addr1", fq.mem_addr,         32'd0);
        waitCycle();
        checkOutput("t3Req2",  {31'd0, fq.mem_req}, 32'd1);
        checkOutput("t3Addr2", fq.mem_addr,         32'd0);
        applyStimulus(1'b1, 32'h0000_0040, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("t3HoldReq",  {31'd0, fq.mem_req},   32'd1);
        checkOutput("t3HoldAddr", fq.mem_addr,           32'd0);
        checkOutput("t3Valid3",   {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        checkOutput("t3NewAddr",  fq.mem_addr,           32'h0000_0040);
        checkOutput("t3NewReq",   {31'd0, fq.mem_req},   32'd1);
        checkOutput("t3Dropped",  {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        waitCycle();
        checkOutput("t3StillEmpty", {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        checkOutput("t3Valid",  {31'd0, fq.out_valid}, 32'd1);
        checkOutput("t3Pc4",    fq.out_pc_plus4,       32'h0000_0044);
        checkOutput("t3Instr",  fq.out_instr,          32'hC0DE_0040);
        checkOutput("t3Next",   fq.mem_addr,           32'h0000_0044);

        // Redirect to 0x100 in the same cycle as an ack
        latency = 1;
        waitCycle();
        checkOutput("t4PrePc4", fq.out_pc_plus4, 32'h0000_0048);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("t4Addr",  fq.mem_addr,           32'h0000_0100);
        checkOutput("t4Req",   {31'd0, fq.mem_req},   32'd1);
        checkOutput("t4Valid", {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        checkOutput("t4Pc4",   fq.out_pc_plus4,       32'h0000_0104);

        // Unaligned target: low bits ignored
        applyStimulus(1'b1, 32'h0000_0203, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 32'd0, 1'b0);
        checkOutput("t5Addr",  fq.mem_addr,           32'h0000_0200);
        checkOutput("t5Valid", {31'd0, fq.out_valid}, 32'd0);
        waitCycle();
        checkOutput("t5Pc4",   fq.out_pc_plus4,       32'h0000_0204);
        checkOutput("t5Instr", fq.out_instr,          32'hC0DE_0200);

        // Reset mid-fetch with two queued entries and a late ack
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitCycle();
        latency = 3;
        checkOutput("t6Pc4",   fq.out_pc_plus4,       32'h0000_0204);
        checkOutput("t6Req",   {31'd0, fq.mem_req},   32'd1);
        #2;
        rst_n      = 1'b0;
        memAuto    = 1'b0;
        manualAck  = 1'b1;
        manualData = 32'hBAD0_BAD0;
        #1;
        checkOutput("t6RstValid", {31'd0, fq.out_valid}, 32'd0);
        checkOutput("t6RstReq",   {31'd0, fq.mem_req},   32'd0);
        checkOutput("t6RstAddr",  fq.mem_addr,           32'd0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("t6LateValid", {31'd0, fq.out_valid}, 32'd0);
        checkOutput("t6RestartReq",  {31'd0, fq.mem_req}, 32'd1);
        checkOutput("t6RestartAddr", fq.mem_addr,         32'd0);
        manualAck = 1'b0;
        latency   = 1;
        memAuto   = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitCycle();
        checkOutput("t6Pc4",   fq.out_pc_plus4, 32'd4);
        checkOutput("t6Instr", fq.out_instr,    32'hC0DE_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID register.
- Replaces the direct PC→InstructionMemory path with a request/acknowledge port to a multi-cycle instruction memory and a DEPTH-entry prefetch FIFO.
- Presents {instruction, pc+4} to IF/ID, holds it under hazard stall, and flushes or redirects on a taken branch or jump resolved in ID.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  instruction fetch request; held until mem_ack.
- mem_addr  output  32  fetch address; word aligned; stable while mem_req=1.
- mem_ack  input  1  memory has returned mem_rdata this cycle.
- mem_rdata  input  32  instruction word; valid only when mem_ack=1.
- redirect  input  1  taken branch/jump from ID (idJump or branch taken).
- redirect_addr  input  32  target address; bits [1:0] are ignored and treated as 0.
- stall  input  1  hazard-detection stall; head entry must not be consumed.
- out_valid  output  1  head entry valid.
- out_instr  output  32  head instruction.
- out_pc_plus4  output  32  head fetch address + 4.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, FIFO count=0, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, out_valid=0.
  - out_instr=0, out_pc_plus4=0.
  - Reset asserted mid-transaction abandons the outstanding request. Memory must tolerate mem_req dropping without an ack.
- Protocol:
  - At most one request outstanding.
  - mem_req and mem_addr are registered outputs and change only on clk edges.
  - Once mem_req=1, mem_req and mem_addr hold until the cycle with mem_ack=1, even across a redirect.
  - mem_ack while mem_req=0 is ignored.
- Issue credit:
  - A new request may be issued only if count + (outstanding?1:0) < DEPTH after this cycle's push and pop.
  - With a zero-wait memory (ack in the cycle after mem_req rises), sustained throughput is one instruction per cycle.
- States:
  - IDLE: no request outstanding. If redirect, load fetch_pc from redirect_addr. If credit is available, set mem_req=1 and mem_addr=fetch_pc (or redirect_addr if redirecting), then go to WAIT.
  - WAIT: request outstanding, result wanted.
    - mem_ack without redirect: push {mem_rdata, mem_addr+4} and set fetch_pc=mem_addr+4. If credit remains, issue the next address back-to-back; otherwise mem_req=0 and go to IDLE.
    - redirect without mem_ack: go to DISCARD, hold mem_req, set fetch_pc=redirect_addr.
    - redirect with mem_ack: drop the data and issue redirect_addr immediately (credit is always available after a flush).
  - DISCARD: stale request outstanding.
    - On mem_ack: drop the data, issue fetch_pc, go to WAIT.
    - A further redirect in DISCARD only updates fetch_pc.
- FIFO:
  - out_* reflect the head combinationally from storage. out_valid = (count ≠ 0).
  - Pop when out_valid=1 and stall=0 and redirect=0.
  - Simultaneous push and pop leaves count unchanged.
  - Push is never attempted when full; the credit rule guarantees this. The bench checks this with an assertion.
  - Pointers wrap modulo DEPTH.
- Redirect:
  - In the same cycle, count becomes 0 and any push from that cycle's ack is suppressed.
  - Redirect overrides stall and pop.
  - The next cycle has out_valid=0.
  - The first valid entry after a redirect always has out_pc_plus4 = target+4.
- Arithmetic: the +4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

Test Plan:
1. Reset, then rst_n=1 with a zero-wait memory (ack the cycle after req):
   - mem_addr sequence 0, 4, 8, 12, …
   - out_pc_plus4 sequence 4, 8, 12, …
   - one instruction per cycle after the first two cycles.
2. stall=1 for 6 cycles during streaming:
   - head holds its value.
   - count reaches 4, then mem_req falls to 0.
   - after stall drops, mem_req resumes at the next address with no skipped or duplicated PC.
3. Memory with 3-cycle ack latency; redirect to 32'h0000_0040 in the second wait cycle:
   - mem_req/mem_addr stay held until ack.
   - that ack's data is dropped.
   - next request is 0x40; first out_pc_plus4 = 0x44.
4. redirect (target 0x100) in the same cycle as mem_ack:
   - no push.
   - next cycle mem_addr=0x100 and out_valid=0.
5. redirect_addr = 0x0000_0203:
   - request issued at 0x200.
6. rst_n pulsed low mid-WAIT with 2 FIFO entries:
   - immediately out_valid=0 and mem_req=0.
   - after release, fetch restarts at RESET_PC.
   - a late ack arriving during or after reset produces no push.
